// File: rtl/max_unpool_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max_unpool_pkg
// Description : Shared types and argmax position codes for the 2x2 unpool.
// Revision    : 1.0 - initial release
// ============================================================================
package max_unpool_pkg;

    typedef enum logic [0:0] {
        TOP = 1'b0,
        BOT = 1'b1
    } state_t;

    localparam int IDX_W = 2;

    // Argmax position within a 2x2 window, encoded as dy*2+dx
    localparam logic [IDX_W-1:0] POS_TL = 2'd0;
    localparam logic [IDX_W-1:0] POS_TR = 2'd1;
    localparam logic [IDX_W-1:0] POS_BL = 2'd2;
    localparam logic [IDX_W-1:0] POS_BR = 2'd3;

endpackage
`default_nettype wire

// File: rtl/max_unpool_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : max_unpool_stream_if
// Description : Pooled-element input stream and full-resolution output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface max_unpool_stream_if
    import max_unpool_pkg::*;
#(
    parameter int BITWIDTH = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_data;
    logic [IDX_W-1:0]    in_idx;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] out_data;
    logic                out_last;

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/max_unpool_stream_row_buf.sv
`default_nettype none
// ============================================================================
// Module      : unpool_row_buf
// Description : One pooled row of {idx, data}; synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module unpool_row_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 10,
    parameter int AW    = 4
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [AW-1:0]    waddr,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic [AW-1:0]    raddr,
    output logic      [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule
`default_nettype wire

// File: rtl/max_unpool_stream.sv
`default_nettype none
// ============================================================================
// Module      : max_unpool_stream
// Description : Streaming 2x2 max-unpool; pooled elements in, raster pixels out.
// Revision    : 1.0 - initial release
// ============================================================================
module max_unpool_stream
    import max_unpool_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int DATAWIDTH   = 28,
    parameter int DATAHEIGHT  = 28,
    parameter int DATACHANNEL = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    max_unpool_stream_if.slave bus
);
    localparam int c_PW = DATAWIDTH / 2;
    localparam int c_PH = DATAHEIGHT / 2;
    localparam int c_AW = (c_PW > 1) ? $clog2(c_PW) : 1;
    localparam int c_CW = $clog2(DATAWIDTH);
    localparam int c_RW = (c_PH > 1) ? $clog2(c_PH) : 1;
    localparam int c_HW = (DATACHANNEL > 1) ? $clog2(DATACHANNEL) : 1;
    localparam int c_BW = BITWIDTH + IDX_W;

    localparam logic [c_CW-1:0] c_COL_ONE      = c_CW'(1);
    localparam logic [c_CW-1:0] c_COL_TOP_LAST = c_CW'(c_PW - 1);
    localparam logic [c_CW-1:0] c_COL_BOT_LAST = c_CW'(DATAWIDTH - 1);
    localparam logic [c_RW-1:0] c_ROW_ONE      = c_RW'(1);
    localparam logic [c_RW-1:0] c_ROW_LAST     = c_RW'(c_PH - 1);
    localparam logic [c_HW-1:0] c_CH_ONE       = c_HW'(1);
    localparam logic [c_HW-1:0] c_CH_LAST      = c_HW'(DATACHANNEL - 1);

    state_t              r_state;
    logic                r_phase;
    logic [c_CW-1:0]     r_col;
    logic [c_RW-1:0]     r_prow;
    logic [c_HW-1:0]     r_chan;
    logic                r_out_valid;
    logic [BITWIDTH-1:0] r_out_data;
    logic                r_out_last;

    logic                w_free;
    logic                w_in_ready;
    logic                w_accept;
    logic [c_AW-1:0]     w_waddr;
    logic [c_AW-1:0]     w_raddr;
    logic [c_BW-1:0]     w_rd;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [BITWIDTH-1:0] w_rd_data;
    logic [IDX_W-1:0]    w_bot_pos;

    assign w_free     = !r_out_valid || bus.out_ready;
    assign w_in_ready = !rst && (r_state == TOP) && !r_phase && w_free;
    assign w_accept   = bus.in_valid && w_in_ready;

    // TOP reads the entry just written; BOT walks each entry twice (dx = 0, 1)
    assign w_waddr   = r_col[c_AW-1:0];
    assign w_raddr   = (r_state == TOP) ? r_col[c_AW-1:0] : c_AW'(r_col >> 1);
    assign w_rd_idx  = w_rd[BITWIDTH +: IDX_W];
    assign w_rd_data = w_rd[BITWIDTH-1:0];
    assign w_bot_pos = r_col[0] ? POS_BR : POS_BL;

    unpool_row_buf #(
        .DEPTH (c_PW),
        .WIDTH (c_BW),
        .AW    (c_AW)
    ) u_row_buf (
        .clk   (clk),
        .we    (w_accept),
        .waddr (w_waddr),
        .wdata ({bus.in_idx, bus.in_data}),
        .raddr (w_raddr),
        .rdata (w_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= TOP;
            r_phase     <= 1'b0;
            r_col       <= '0;
            r_prow      <= '0;
            r_chan      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                TOP: begin
                    if (!r_phase) begin
                        if (w_accept) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= (bus.in_idx == POS_TL) ? bus.in_data : '0;
                            r_out_last  <= 1'b0;
                            r_phase     <= 1'b1;
                        end else if (w_free) begin
                            r_out_valid <= 1'b0;
                        end
                    end else if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= (w_rd_idx == POS_TR) ? w_rd_data : '0;
                        r_out_last  <= 1'b0;
                        r_phase     <= 1'b0;
                        if (r_col == c_COL_TOP_LAST) begin
                            r_col   <= '0;
                            r_state <= BOT;
                        end else begin
                            r_col <= r_col + c_COL_ONE;
                        end
                    end
                end
                BOT: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= (w_rd_idx == w_bot_pos) ? w_rd_data : '0;
                        r_out_last  <= (r_col == c_COL_BOT_LAST) && (r_prow == c_ROW_LAST);
                        if (r_col == c_COL_BOT_LAST) begin
                            r_col   <= '0;
                            r_state <= TOP;
                            if (r_prow == c_ROW_LAST) begin
                                r_prow <= '0;
                                r_chan <= (r_chan == c_CH_LAST) ? '0 : r_chan + c_CH_ONE;
                            end else begin
                                r_prow <= r_prow + c_ROW_ONE;
                            end
                        end else begin
                            r_col <= r_col + c_COL_ONE;
                        end
                    end
                end
                default: r_state <= TOP;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_max_unpool_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_unpool_stream
// Description : Directed self-checking bench for the 4x4 (x2 channel) unpool.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_unpool_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;

    max_unpool_stream_if #(.BITWIDTH(8)) bus ();

    max_unpool_stream #(
        .BITWIDTH    (8),
        .DATAWIDTH   (4),
        .DATAHEIGHT  (4),
        .DATACHANNEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    int         tmo = 0;
    int         ir_viol = 0;
    int         hold_viol = 0;
    int         n_acc = 0;
    int         n_hs = 0;
    logic [8:0] q [$];
    logic [8:0] prev;
    bit         have_prev = 0;
    bit         ready_mode = 0;

    // Output collector plus in_ready/hold rule monitor, sampled mid-cycle
    always @(negedge clk) begin : mon
        int l_loaded;
        int l_exp;
        if (rst) begin
            q.delete();
            n_acc = 0;
            n_hs = 0;
            have_prev = 0;
        end else begin
            if (bus.in_ready) begin
                l_loaded = n_hs + (bus.out_valid ? 1 : 0);
                l_exp = 8 * (n_acc / 2) + 2 * (n_acc % 2);
                if (l_loaded != l_exp) ir_viol++;
            end
            if (bus.in_valid && bus.in_ready) n_acc++;
            if (have_prev && ({bus.out_last, bus.out_data} !== prev)) hold_viol++;
            have_prev = bus.out_valid && !bus.out_ready;
            prev = {bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
                q.push_back({bus.out_last, bus.out_data});
                n_hs++;
            end
        end
    end

    initial begin : ready_drv
        int cyc;
        cyc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else bus.out_ready = 1'b1;
            cyc++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one element, wait (bounded) for acceptance, then idle 'gap' cycles
    task automatic send(input logic [7:0] d, input logic [1:0] ix, input int gap);
        bit done;
        done = 0;
        bus.in_data  = d;
        bus.in_idx   = ix;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) tmo++;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_basic(input int gap);
        send(8'h11, 2'd0, gap);
        send(8'h22, 2'd3, gap);
        send(8'h33, 2'd1, gap);
        send(8'h44, 2'd2, gap);
    endtask

    task automatic wait_pixels(input int n);
        for (int k = 0; k < 400 && q.size() < n; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_idx   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passes++;
        checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", bus.out_data); else passes++;
        checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", bus.out_last); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); else passes++;
    endtask

    task automatic test_basic();
        logic [7:0] e [16] = '{8'h11, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h22,
                               8'h00, 8'h33, 8'h00, 8'h00,  8'h00, 8'h00, 8'h44, 8'h00};
        logic [8:0] got;
        q.delete();
        send_basic(0);
        wait_pixels(16);
        checks++; if (q.size() != 16) $display("FAIL basic_count got=%0d exp=16", q.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15), e[i]}) $display("FAIL basic_px%0d got=%h exp=%h", i, got, {(i == 15), e[i]});
            else passes++;
        end
        checks++; if (tmo != 0) $display("FAIL basic_accept_timeout got=%0d exp=0", tmo); else passes++;
    endtask

    task automatic test_backpressure();
        logic [7:0] e [16] = '{8'h11, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h22,
                               8'h00, 8'h33, 8'h00, 8'h00,  8'h00, 8'h00, 8'h44, 8'h00};
        logic [8:0] got;
        q.delete();
        ready_mode = 1;
        send_basic(0);
        wait_pixels(16);
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (q.size() != 16) $display("FAIL bp_count got=%0d exp=16", q.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15), e[i]}) $display("FAIL bp_px%0d got=%h exp=%h", i, got, {(i == 15), e[i]});
            else passes++;
        end
        checks++; if (hold_viol != 0) $display("FAIL bp_hold got=%0d changes exp=0", hold_viol); else passes++;
    endtask

    task automatic test_multichannel();
        logic [7:0] e [32] = '{8'h01, 8'h00, 8'h02, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
                               8'h03, 8'h00, 8'h04, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
                               8'h05, 8'h00, 8'h06, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
                               8'h07, 8'h00, 8'h08, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] e3 [16] = '{8'h00, 8'h09, 8'h0a, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00,  8'h0b, 8'h00, 8'h00, 8'h0c};
        logic [8:0] got;
        q.delete();
        for (int v = 1; v <= 8; v++) send(8'(v), 2'd0, 0);
        wait_pixels(32);
        checks++; if (q.size() != 32) $display("FAIL mc_count got=%0d exp=32", q.size()); else passes++;
        for (int i = 0; i < 32; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15 || i == 31), e[i]}) $display("FAIL mc_px%0d got=%h exp=%h", i, got, {(i == 15 || i == 31), e[i]});
            else passes++;
        end
        q.delete();
        send(8'h09, 2'd1, 0);
        send(8'h0a, 2'd0, 0);
        send(8'h0b, 2'd2, 0);
        send(8'h0c, 2'd3, 0);
        wait_pixels(16);
        checks++; if (q.size() != 16) $display("FAIL mc3_count got=%0d exp=16", q.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15), e3[i]}) $display("FAIL mc3_px%0d got=%h exp=%h", i, got, {(i == 15), e3[i]});
            else passes++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] e [16] = '{8'h11, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h22,
                               8'h00, 8'h33, 8'h00, 8'h00,  8'h00, 8'h00, 8'h44, 8'h00};
        logic [8:0] got;
        q.delete();
        send_basic(5);
        wait_pixels(16);
        checks++; if (q.size() != 16) $display("FAIL gap_count got=%0d exp=16", q.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15), e[i]}) $display("FAIL gap_px%0d got=%h exp=%h", i, got, {(i == 15), e[i]});
            else passes++;
        end
        checks++; if (ir_viol != 0) $display("FAIL gap_in_ready_rule got=%0d violations exp=0", ir_viol); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL gap_idle_valid got=%b exp=0", bus.out_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e [16] = '{8'h00, 8'h00, 8'h00, 8'h00,  8'h00, 8'ha1, 8'h00, 8'ha2,
                               8'h00, 8'h00, 8'h00, 8'h00,  8'h00, 8'ha3, 8'h00, 8'ha4};
        logic [8:0] got;
        send(8'h51, 2'd0, 0);
        send(8'h52, 2'd1, 0);
        send(8'h53, 2'd0, 0);
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL rstmid_in_ready got=%b exp=0", bus.in_ready); else passes++;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        send(8'ha1, 2'd3, 0);
        send(8'ha2, 2'd3, 0);
        send(8'ha3, 2'd3, 0);
        send(8'ha4, 2'd3, 0);
        wait_pixels(16);
        checks++; if (q.size() != 16) $display("FAIL rstmid_count got=%0d exp=16", q.size()); else passes++;
        for (int i = 0; i < 16; i++) begin
            got = (i < q.size()) ? q[i] : 9'h1ff;
            checks++;
            if (got !== {(i == 15), e[i]}) $display("FAIL rstmid_px%0d got=%h exp=%h", i, got, {(i == 15), e[i]});
            else passes++;
        end
        checks++; if (tmo != 0) $display("FAIL accept_timeout got=%0d exp=0", tmo); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_multichannel();
        test_gaps();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
